// File: rtl/fc_layer_engine_if.sv
// Bus between a layer engine and its controller/memories: run/done level
// protocol, activation+weight read port and result write port.
interface fc_layer_engine_if #(
  parameter int IN_LEN  = 784,
  parameter int OUT_LEN = 128,
  parameter int DATA_W  = 8
);
  localparam int AW = $clog2(IN_LEN + 1);
  localparam int OW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

  // run is a level: the engine starts on run=1 in IDLE, aborts on run=0 while
  // busy, and after done waits for run=0 before it can be started again.
  // No backpressure: read data is valid exactly one cycle after act_en, and
  // every wr_en cycle is one accepted result.
  logic                      run;
  logic                      act_en;
  logic [AW-1:0]             act_addr;
  logic [DATA_W-1:0]         act_data;
  logic [OUT_LEN*DATA_W-1:0] wt_row;
  logic                      wr_en;
  logic [OW-1:0]             wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      busy;
  logic                      done;

  modport master (
    output run, act_data, wt_row,
    input  act_en, act_addr, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  run, act_data, wt_row,
    output act_en, act_addr, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: sweeps IN_LEN activation rows plus a bias row,
// accumulates OUT_LEN neurons in parallel, then writes ReLU/requantised results.
module fc_layer_engine #(
  parameter int IN_LEN  = 784,
  parameter int OUT_LEN = 128,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int SHIFT   = 7
) (
  input  logic                clk,
  input  logic                rst,
  fc_layer_engine_if.slave    bus,
  output logic [2:0]          dbg_state
);
  localparam int AW = $clog2(IN_LEN + 1);
  localparam int OW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam int PW = 2 * DATA_W;
  localparam logic [AW-1:0] LAST_ROW = AW'(IN_LEN);
  localparam logic [OW-1:0] LAST_IDX = OW'(OUT_LEN - 1);
  localparam logic signed [ACC_W-1:0] MAX_Q = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [DATA_W-1:0] ONE = DATA_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCUM, S_DRAIN, S_WRITE, S_DONE, S_WAIT_LOW
  } state_t;

  state_t state, state_nxt;

  logic                     act_en_q, rd_vld, rd_bias;
  logic [AW-1:0]            act_addr_q;
  logic [OW-1:0]            widx;
  logic                     wr_en_q, done_q;
  logic [OW-1:0]            wr_addr_q;
  logic [DATA_W-1:0]        wr_data_q, wr_data_nxt;
  logic signed [ACC_W-1:0]  acc [OUT_LEN];
  logic signed [PW-1:0]     prod [OUT_LEN];
  logic signed [DATA_W-1:0] act_sel;
  logic signed [ACC_W-1:0]  cur, relu, shifted;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (bus.run) state_nxt = S_ACCUM;
      S_ACCUM:    if (!bus.run) state_nxt = S_IDLE;
                  else if (act_addr_q == LAST_ROW) state_nxt = S_DRAIN;
      S_DRAIN:    state_nxt = bus.run ? S_WRITE : S_IDLE;
      S_WRITE:    if (!bus.run) state_nxt = S_IDLE;
                  else if (widx == LAST_IDX) state_nxt = S_DONE;
      S_DONE:     state_nxt = bus.run ? S_WAIT_LOW : S_IDLE;
      S_WAIT_LOW: if (!bus.run) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // The bias row reuses the MAC path with the activation forced to one.
  always_comb begin
    act_sel = rd_bias ? ONE : $signed(bus.act_data);
    for (int j = 0; j < OUT_LEN; j++) begin
      prod[j] = PW'(act_sel) * PW'($signed(bus.wt_row[j*DATA_W +: DATA_W]));
    end
  end

  always_comb begin
    cur         = acc[widx];
    relu        = cur[ACC_W-1] ? '0 : cur;
    shifted     = relu >>> SHIFT;
    wr_data_nxt = (shifted > MAX_Q) ? MAX_Q[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      act_en_q   <= 1'b0;
      act_addr_q <= '0;
      rd_vld     <= 1'b0;
      rd_bias    <= 1'b0;
      widx       <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      for (int j = 0; j < OUT_LEN; j++) acc[j] <= '0;
    end else begin
      state    <= state_nxt;
      done_q   <= (state == S_DONE);
      rd_vld   <= act_en_q;
      rd_bias  <= act_en_q && (act_addr_q == LAST_ROW);
      act_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      if (rd_vld) begin
        for (int j = 0; j < OUT_LEN; j++) acc[j] <= acc[j] + ACC_W'(prod[j]);
      end
      // A start clears the accumulators even if a stale read lands this cycle.
      case (state)
        S_IDLE: if (bus.run) begin
          act_en_q   <= 1'b1;
          act_addr_q <= '0;
          for (int j = 0; j < OUT_LEN; j++) acc[j] <= '0;
        end
        S_ACCUM: if (bus.run && act_addr_q != LAST_ROW) begin
          act_en_q   <= 1'b1;
          act_addr_q <= act_addr_q + 1'b1;
        end
        S_DRAIN: widx <= '0;
        S_WRITE: if (bus.run) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= widx;
          wr_data_q <= wr_data_nxt;
          widx      <= widx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.act_en   = act_en_q;
  assign bus.act_addr = act_addr_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state == S_ACCUM) || (state == S_DRAIN) || (state == S_WRITE);
  assign dbg_state    = state;
endmodule
